// File: rtl/cam_frame_scaler_pkg.sv
// Shared constants for the camera read-side scaler: RGB332 colours, colour-bar ROM and
// scale_sel encodings.
package cam_frame_scaler_pkg;

    typedef enum logic [1:0] {
        SCALE_1X  = 2'b00,
        SCALE_2X  = 2'b01,
        SCALE_4X  = 2'b10,
        SCALE_RSV = 2'b11
    } scale_e;

    localparam logic [7:0] RED_VGA   = 8'hE0;
    localparam logic [7:0] GREEN_VGA = 8'h1C;
    localparam logic [7:0] BLUE_VGA  = 8'h03;

    localparam logic [7:0] BAR_WHITE   = 8'hFF;
    localparam logic [7:0] BAR_YELLOW  = 8'hFC;
    localparam logic [7:0] BAR_CYAN    = 8'h1F;
    localparam logic [7:0] BAR_GREEN   = 8'h1C;
    localparam logic [7:0] BAR_MAGENTA = 8'hE3;
    localparam logic [7:0] BAR_RED     = 8'hE0;
    localparam logic [7:0] BAR_BLUE    = 8'h03;
    localparam logic [7:0] BAR_BLACK   = 8'h00;

    // Scale factors are powers of two, so everything downstream uses shifts.
    function automatic logic [1:0] scale_shift(input scale_e s);
        case (s)
            SCALE_2X: scale_shift = 2'd1;
            SCALE_4X: scale_shift = 2'd2;
            default:  scale_shift = 2'd0;
        endcase
    endfunction

    function automatic logic [7:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = BAR_WHITE;
            3'd1:    bar_color = BAR_YELLOW;
            3'd2:    bar_color = BAR_CYAN;
            3'd3:    bar_color = BAR_GREEN;
            3'd4:    bar_color = BAR_MAGENTA;
            3'd5:    bar_color = BAR_RED;
            3'd6:    bar_color = BAR_BLUE;
            default: bar_color = BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/cam_color_bars.sv
// Eight vertical colour bars for the test-pattern path; only built when
// CAM_FRAME_SCALER_TEST_PATTERN_EN is defined.
`ifdef CAM_FRAME_SCALER_TEST_PATTERN_EN
module cam_color_bars
    import cam_frame_scaler_pkg::*;
#(
    parameter int CAM_X   = 160,
    parameter int RAM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       col_start,
    input  logic       col_step,
    output logic [7:0] bar_rgb
);
    localparam int BAR_W = CAM_X / 8;
    localparam int SW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    logic [2:0]              bar_q, bar_n;
    logic [SW-1:0]           step_q, step_n;
    logic [RAM_LAT:0][7:0]   rgb_pipe;

    // Bar index for the current pixel, stepped once per BAR_W buffer columns.
    always_comb begin
        bar_n  = bar_q;
        step_n = step_q;
        if (col_start) begin
            bar_n  = '0;
            step_n = '0;
        end else if (col_step) begin
            if (step_q == SW'(BAR_W - 1)) begin
                step_n = '0;
                bar_n  = bar_q + 3'd1;
            end else begin
                step_n = step_q + SW'(1);
            end
        end
    end

    // Colour is delayed to line up with mem_data at the pixel output stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bar_q    <= '0;
            step_q   <= '0;
            rgb_pipe <= '0;
        end else begin
            bar_q    <= bar_n;
            step_q   <= step_n;
            rgb_pipe <= {rgb_pipe[RAM_LAT-1:0], bar_color(bar_n)};
        end
    end

    assign bar_rgb = rgb_pipe[RAM_LAT];

endmodule
`endif

// File: rtl/cam_frame_scaler.sv
// Frame-buffer read address generator and pixel pipeline with 1x/2x/4x upscale.
// Optional test-pattern input under CAM_FRAME_SCALER_TEST_PATTERN_EN.
module cam_frame_scaler
    import cam_frame_scaler_pkg::*;
#(
    parameter int            CAM_X   = 160,
    parameter int            CAM_Y   = 120,
    parameter int            AW      = 15,
    parameter int            DW      = 8,
    parameter int            OFF_X   = 0,
    parameter int            OFF_Y   = 0,
    parameter logic [DW-1:0] FILL    = '0,
    parameter int            RAM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    posX,
    input  logic [8:0]    posY,
    input  logic [1:0]    scale_sel,
`ifdef CAM_FRAME_SCALER_TEST_PATTERN_EN
    input  logic          pattern_en,
`endif
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic [DW-1:0] pixel_out,
    output logic          px_valid
);
    localparam logic [AW-1:0] ADDR_FILL = {AW{1'b1}};

    scale_e          scale_q, scale_eff;
    logic [1:0]      shamt, s_minus1;
    logic [2:0]      s_val;
    logic            frame_start, col_start, x_in, y_in, in_win;
    logic [AW-1:0]   col_q, col_n, row_q, row_n, addr_n;
    logic [1:0]      subx_q, subx_n, suby_q, suby_n;
    logic            line_win_q, line_win_n;
    logic [RAM_LAT:0] win_pipe;
    logic [DW-1:0]   pix_src;

    assign frame_start = (posX == 10'd0) && (posY == 9'd0);
    assign col_start   = (posX == 10'(OFF_X));
    assign scale_eff   = frame_start ? scale_e'(scale_sel) : scale_q;
    assign shamt       = scale_shift(scale_eff);
    assign s_val       = 3'd1 << shamt;
    assign s_minus1    = 2'(s_val - 3'd1);

    // Positions left of / above the window wrap to huge values, so one compare suffices.
    assign x_in   = (12'(posX) - 12'(OFF_X)) < (12'(CAM_X) << shamt);
    assign y_in   = (12'(posY) - 12'(OFF_Y)) < (12'(CAM_Y) << shamt);
    assign in_win = x_in && y_in;

    always_comb begin
        col_n  = col_q;
        subx_n = subx_q;
        if (col_start) begin
            col_n  = '0;
            subx_n = '0;
        end else if (x_in) begin
            if (subx_q == s_minus1) begin
                subx_n = '0;
                col_n  = col_q + AW'(1);
            end else begin
                subx_n = subx_q + 2'd1;
            end
        end
    end

    // Line counters only move at the start of each scanned line.
    always_comb begin
        row_n      = row_q;
        suby_n     = suby_q;
        line_win_n = line_win_q;
        if (posX == 10'd0) begin
            line_win_n = y_in;
            if (posY == 9'(OFF_Y)) begin
                row_n  = '0;
                suby_n = '0;
            end else if (line_win_q) begin
                if (suby_q == s_minus1) begin
                    suby_n = '0;
                    row_n  = row_q + AW'(CAM_X);
                end else begin
                    suby_n = suby_q + 2'd1;
                end
            end
        end
    end

    assign addr_n = row_n + col_n;

`ifdef CAM_FRAME_SCALER_TEST_PATTERN_EN
    logic [7:0] bar_rgb;
    logic       col_step;

    assign col_step = x_in && !col_start && (subx_q == s_minus1);

    cam_color_bars #(
        .CAM_X   (CAM_X),
        .RAM_LAT (RAM_LAT)
    ) u_bars (
        .clk       (clk),
        .rst       (rst),
        .col_start (col_start),
        .col_step  (col_step),
        .bar_rgb   (bar_rgb)
    );

    assign pix_src = pattern_en ? DW'(bar_rgb) : mem_data;
`else
    assign pix_src = mem_data;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scale_q    <= SCALE_1X;
            col_q      <= '0;
            subx_q     <= '0;
            row_q      <= '0;
            suby_q     <= '0;
            line_win_q <= 1'b0;
            mem_addr   <= ADDR_FILL;
            win_pipe   <= '0;
            pixel_out  <= '0;
            px_valid   <= 1'b0;
        end else begin
            scale_q    <= scale_eff;
            col_q      <= col_n;
            subx_q     <= subx_n;
            row_q      <= row_n;
            suby_q     <= suby_n;
            line_win_q <= line_win_n;
            mem_addr   <= in_win ? addr_n : ADDR_FILL;
            win_pipe   <= {win_pipe[RAM_LAT-1:0], in_win};
            pixel_out  <= win_pipe[RAM_LAT] ? pix_src : FILL;
            px_valid   <= win_pipe[RAM_LAT];
        end
    end

endmodule

// File: tb/tb_cam_frame_scaler.sv
// Directed bench for cam_frame_scaler: partial raster scans at each scale with a
// latency-aligned model and hand-computed probe points.
module tb_cam_frame_scaler;
    localparam int ADDR_FILL = 32767;
    localparam int FILL_PIX  = 0;

    logic        clk;
    logic        rst;
    logic [9:0]  posX;
    logic [8:0]  posY;
    logic [1:0]  scale_sel;
`ifdef CAM_FRAME_SCALER_TEST_PATTERN_EN
    logic        pattern_en;
    bit          pattern_on;
    int          bar_tab [8] = '{255, 252, 31, 28, 227, 224, 3, 0};
`endif
    logic [14:0] mem_addr;
    logic [7:0]  mem_data;
    logic [7:0]  pixel_out;
    logic        px_valid;

    typedef struct {
        int    x;
        int    y;
        int    val;
        bit    is_pix;
        string tag;
    } probe_t;

    probe_t probes[$];
    int     pipe_addr [1:3];
    int     pipe_x    [1:3];
    int     pipe_y    [1:3];
    bit     pipe_ok   [1:3];
    int     act_scale;
    bit     check_en;
    int     vectors     = 0;
    int     miscompares = 0;

    cam_frame_scaler dut (
        .clk       (clk),
        .rst       (rst),
        .posX      (posX),
        .posY      (posY),
        .scale_sel (scale_sel),
`ifdef CAM_FRAME_SCALER_TEST_PATTERN_EN
        .pattern_en(pattern_en),
`endif
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .pixel_out (pixel_out),
        .px_valid  (px_valid)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Buffer RAM stand-in: one cycle of latency, data equals the low address byte.
    always @(posedge clk) mem_data <= mem_addr[7:0];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (posX=%0d posY=%0d)",
                     tag, observed, expected, posX, posY);
        end
    endtask

    function automatic int modelAddr(input int x, input int y, input int s);
        if (x < 160 * s && y < 120 * s)
            return (y / s) * 160 + x / s;
        return ADDR_FILL;
    endfunction

    function automatic int modelPixel(input int a);
        if (a == ADDR_FILL)
            return FILL_PIX;
`ifdef CAM_FRAME_SCALER_TEST_PATTERN_EN
        if (pattern_on)
            return bar_tab[(a % 160) / 20];
`endif
        return a % 256;
    endfunction

    task automatic addProbe(input int x, input int y, input int val, input bit is_pix,
                            input string tag);
        probe_t p;
        p.x = x; p.y = y; p.val = val; p.is_pix = is_pix; p.tag = tag;
        probes.push_back(p);
    endtask

    // Check what earlier drives produced, then present the next scan position.
    task automatic applyStimulus(input int x, input int y);
        @(negedge clk);
        if (pipe_ok[1]) begin
            checkOutput("addr", 32'(mem_addr), 32'(pipe_addr[1]));
            foreach (probes[i])
                if (!probes[i].is_pix && probes[i].x == pipe_x[1] && probes[i].y == pipe_y[1])
                    checkOutput(probes[i].tag, 32'(mem_addr), 32'(probes[i].val));
        end
        if (pipe_ok[3]) begin
            checkOutput("pixel", 32'(pixel_out), 32'(modelPixel(pipe_addr[3])));
            checkOutput("px_valid", 32'(px_valid), 32'(pipe_addr[3] != ADDR_FILL));
            foreach (probes[i])
                if (probes[i].is_pix && probes[i].x == pipe_x[3] && probes[i].y == pipe_y[3])
                    checkOutput(probes[i].tag, 32'(pixel_out), 32'(probes[i].val));
        end
        if (x == 0 && y == 0)
            act_scale = (scale_sel == 2'b01) ? 2 : (scale_sel == 2'b10) ? 4 : 1;
        for (int k = 3; k > 1; k--) begin
            pipe_addr[k] = pipe_addr[k-1];
            pipe_x[k]    = pipe_x[k-1];
            pipe_y[k]    = pipe_y[k-1];
            pipe_ok[k]   = pipe_ok[k-1];
        end
        pipe_addr[1] = modelAddr(x, y, act_scale);
        pipe_x[1]    = x;
        pipe_y[1]    = y;
        pipe_ok[1]   = check_en;
        posX = 10'(x);
        posY = 9'(y);
    endtask

    task automatic scanRange(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) applyStimulus(x, y);
    endtask

    task automatic scanFrame(input int lines, input int xlast);
        for (int y = 0; y < lines; y++) scanRange(y, 0, xlast);
    endtask

    // Off-screen columns are outside the window at every scale; they drain the pipeline.
    task automatic flushPipe(input int y);
        for (int i = 0; i < 4; i++) applyStimulus(700 + i, y);
    endtask

    initial begin
        #10000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        posX      = '0;
        posY      = '0;
        scale_sel = 2'b00;
`ifdef CAM_FRAME_SCALER_TEST_PATTERN_EN
        pattern_en = 1'b0;
        pattern_on = 1'b0;
`endif
        act_scale = 1;
        check_en  = 1'b0;
        for (int k = 1; k <= 3; k++) pipe_ok[k] = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset_addr", 32'(mem_addr), 32'(ADDR_FILL));
        checkOutput("reset_pixel", 32'(pixel_out), 32'(0));
        checkOutput("reset_valid", 32'(px_valid), 32'(0));
        rst = 1'b1;
        check_en = 1'b1;

        $display("[TB] 1x scan");
        probes.delete();
        addProbe(0, 0, 0, 1'b0, "addr_1x_origin");
        addProbe(5, 2, 325, 1'b0, "addr_1x");
        addProbe(5, 2, 69, 1'b1, "pix_1x");
        addProbe(159, 2, 479, 1'b0, "addr_1x_last_col");
        addProbe(160, 2, ADDR_FILL, 1'b0, "addr_fill");
        addProbe(160, 2, FILL_PIX, 1'b1, "pix_fill");
        scanFrame(2, 7);
        scanRange(2, 0, 170);
        flushPipe(2);

        $display("[TB] 2x scan");
        probes.delete();
        scale_sel = 2'b01;
        addProbe(3, 5, 321, 1'b0, "addr_2x");
        addProbe(319, 239, 19199, 1'b0, "addr_2x_last");
        addProbe(319, 239, 255, 1'b1, "pix_2x_last");
        scanFrame(239, 3);
        scanRange(239, 0, 319);
        flushPipe(239);

        $display("[TB] 4x scan");
        probes.delete();
        scale_sel = 2'b10;
        addProbe(639, 479, 19199, 1'b0, "addr_4x_last");
        addProbe(4, 7, 161, 1'b0, "addr_4x_mid");
        scanFrame(479, 7);
        scanRange(479, 0, 639);
        flushPipe(479);

        $display("[TB] scale latch");
        probes.delete();
        scale_sel = 2'b00;
        addProbe(3, 55, 8803, 1'b0, "latch_still_1x");
        scanFrame(50, 3);
        scale_sel = 2'b01;
        for (int y = 50; y <= 60; y++) scanRange(y, 0, 3);
        flushPipe(60);
        probes.delete();
        addProbe(3, 5, 321, 1'b0, "latched_2x");
        addProbe(3, 49, 3841, 1'b0, "latched_2x_row49");
        scanFrame(50, 3);
        scanRange(50, 0, 10);

        $display("[TB] mid-frame reset");
        #5;
        rst = 1'b0;
        #1;
        checkOutput("midreset_addr", 32'(mem_addr), 32'(ADDR_FILL));
        checkOutput("midreset_pixel", 32'(pixel_out), 32'(0));
        checkOutput("midreset_valid", 32'(px_valid), 32'(0));
        check_en  = 1'b0;
        act_scale = 1;
        for (int k = 1; k <= 3; k++) pipe_ok[k] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        scanRange(51, 0, 3);
        scanRange(52, 0, 3);
        probes.delete();
        scale_sel = 2'b00;
        check_en  = 1'b1;
        addProbe(5, 2, 325, 1'b0, "post_reset_addr");
        scanFrame(2, 3);
        scanRange(2, 0, 7);
        flushPipe(2);

`ifdef CAM_FRAME_SCALER_TEST_PATTERN_EN
        $display("[TB] colour bars");
        probes.delete();
        pattern_en = 1'b1;
        pattern_on = 1'b1;
        addProbe(0, 1, 255, 1'b1, "bar0_first");
        addProbe(19, 1, 255, 1'b1, "bar0_last");
        addProbe(20, 1, 252, 1'b1, "bar1_first");
        addProbe(45, 1, 31, 1'b1, "bar2");
        addProbe(60, 1, 28, 1'b1, "bar3");
        addProbe(99, 1, 227, 1'b1, "bar4_last");
        addProbe(100, 1, 224, 1'b1, "bar5_first");
        addProbe(139, 1, 3, 1'b1, "bar6_last");
        addProbe(159, 1, 0, 1'b1, "bar7_last");
        addProbe(160, 1, FILL_PIX, 1'b1, "bar_fill");
        scanFrame(1, 3);
        scanRange(1, 0, 165);
        flushPipe(1);
        pattern_en = 1'b0;
        pattern_on = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
